// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 boot path.
// Holds the loader state encoding and instruction-word constants.
package mips32_pkg;

   localparam int INSTR_W = 32;
   localparam logic [5:0] HALT = 6'h3f;

   typedef enum logic [2:0] {
      S_LEN_HI = 3'd0,
      S_LEN_LO = 3'd1,
      S_DATA   = 3'd2,
      S_CSUM   = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   // Receive states are the ones that accept stream bytes.
   function automatic logic is_rx(input state_t s);
      return (s != S_DONE) && (s != S_ERR);
   endfunction

endpackage

// File: rtl/mips32_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words.
// word_valid_o pulses with the 4th byte; word_o is then complete.
module mips32_word_assembler
   import mips32_pkg::*;
(
   input  logic               clk1,
   input  logic               rst_n,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic [7:0]         byte_i,
   output logic               word_valid_o,
   output logic [INSTR_W-1:0] word_o
);

   logic [23:0] sr_q;
   logic [1:0]  cnt_q;

   assign word_valid_o = en_i && (cnt_q == 2'd3);
   assign word_o       = {sr_q, byte_i};

   // Shift in accepted bytes; the counter wraps every word.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (clr_i) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (en_i) begin
         sr_q  <= {sr_q[15:0], byte_i};
         cnt_q <= cnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot loader: framed byte stream into instruction memory.
// Core is held in reset until a checksum-verified load completes.
module mips32_prog_loader
   import mips32_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 1024
)
(
   input  logic               clk1,
   input  logic               rst_n,
   input  logic               start,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] mem_wdata,
   output logic               core_rst_n,
   output logic               boot_done,
   output logic               boot_err
);

   localparam logic [16:0] MAX_L = 17'(MAX_WORDS);

   state_t state_q, state_d;

   logic               in_ready_q, in_ready_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [7:0]         len_hi_q;
   logic [15:0]        len_q;
   logic [7:0]         csum_q;
   logic [15:0]        word_cnt_q;
   logic               csum_seen_q;
   logic               csum_ok_q;
   logic               mem_we_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [INSTR_W-1:0] mem_wdata_q;

   logic               xfer;
   logic               data_xfer;
   logic [15:0]        len_w;
   logic               word_valid;
   logic [INSTR_W-1:0] word;
   logic               last_word;

   // After the CSUM byte lands, further bytes are ignored.
   assign xfer      = in_valid && in_ready_q && !csum_seen_q;
   assign data_xfer = xfer && (state_q == S_DATA);
   assign len_w     = {len_hi_q, in_data};
   assign last_word = word_valid && ((word_cnt_q + 16'd1) == len_q);

   mips32_word_assembler u_asm (
      .clk1         (clk1),
      .rst_n        (rst_n),
      .clr_i        (start),
      .en_i         (data_xfer),
      .byte_i       (in_data),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   // State and registered status outputs.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_LEN_HI;
         in_ready_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Frame sequencing; CSUM verdict resolves one edge after the byte.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = S_LEN_HI;
      end else begin
         unique case (state_q)
            S_LEN_HI: if (xfer) state_d = S_LEN_LO;
            S_LEN_LO: begin
               if (xfer) begin
                  if ({1'b0, len_w} > MAX_L)
                     state_d = S_ERR;
                  else if (len_w == 16'd0)
                     state_d = S_CSUM;
                  else
                     state_d = S_DATA;
               end
            end
            S_DATA:   if (last_word) state_d = S_CSUM;
            S_CSUM: begin
               if (csum_seen_q)
                  state_d = csum_ok_q ? S_DONE : S_ERR;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Status outputs follow the state being entered.
   always_comb begin
      in_ready_d = is_rx(state_d);
      done_d     = (state_d == S_DONE);
      err_d      = (state_d == S_ERR);
   end

   // Length capture, checksum, word counter and memory write port.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         len_hi_q    <= '0;
         len_q       <= '0;
         csum_q      <= '0;
         word_cnt_q  <= '0;
         csum_seen_q <= 1'b0;
         csum_ok_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         mem_we_q <= 1'b0;
         if (start) begin
            csum_q      <= '0;
            word_cnt_q  <= '0;
            csum_seen_q <= 1'b0;
            csum_ok_q   <= 1'b0;
         end else begin
            if (xfer && state_q == S_LEN_HI)
               len_hi_q <= in_data;
            if (xfer && state_q == S_LEN_LO)
               len_q <= len_w;
            if (data_xfer)
               csum_q <= csum_q ^ in_data;
            if (word_valid) begin
               mem_we_q    <= 1'b1;
               mem_addr_q  <= word_cnt_q[ADDR_W-1:0];
               mem_wdata_q <= word;
               word_cnt_q  <= word_cnt_q + 16'd1;
            end
            if (xfer && state_q == S_CSUM) begin
               csum_seen_q <= 1'b1;
               csum_ok_q   <= (in_data == csum_q);
            end
         end
      end
   end

   assign in_ready   = in_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign boot_done  = done_q;
   assign boot_err   = err_q;
   assign core_rst_n = done_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for the MIPS32 program loader.
// Expected words, addresses and checksums are hand-computed constants.
module tb_mips32_prog_loader;

   logic        clk1 = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        core_rst_n;
   logic        boot_done;
   logic        boot_err;

   int checks = 0;
   int failures = 0;

   logic [31:0] pw [16];
   logic [9:0]  wa_q [$];
   logic [31:0] wd_q [$];

   mips32_prog_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
      .clk1       (clk1),
      .rst_n      (rst_n),
      .start      (start),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .core_rst_n (core_rst_n),
      .boot_done  (boot_done),
      .boot_err   (boot_err)
   );

   always #5 clk1 = ~clk1;

   // Log every memory write, sampled mid-cycle.
   always @(negedge clk1) begin
      if (mem_we) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wdata);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) step();
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      checks++;
      if (n >= 50) begin
         failures++;
         $error("FAIL rdy_timeout observed=%0d expected=<50", n);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] len, input int nw,
                             input logic [7:0] cs, input int mg);
      logic [31:0] w;
      send_byte(len[15:8], $urandom_range(mg, 0));
      send_byte(len[7:0], $urandom_range(mg, 0));
      for (int i = 0; i < nw; i++) begin
         w = pw[i];
         send_byte(w[31:24], $urandom_range(mg, 0));
         send_byte(w[23:16], $urandom_range(mg, 0));
         send_byte(w[15:8], $urandom_range(mg, 0));
         send_byte(w[7:0], $urandom_range(mg, 0));
      end
      send_byte(cs, $urandom_range(mg, 0));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic chk_writes(input string tag, input int n);
      chk({tag, "_count"}, wa_q.size(), n);
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
         chk({tag, "_addr"}, 32'(wa_q[i]), i);
         chk({tag, "_data"}, wd_q[i], pw[i]);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_rdy"}, in_ready, 0);
      chk({tag, "_we"}, mem_we, 0);
      chk({tag, "_addr"}, 32'(mem_addr), 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_crst"}, core_rst_n, 0);
      chk({tag, "_done"}, boot_done, 0);
      chk({tag, "_err"}, boot_err, 0);
   endtask

   task automatic load_nominal();
      pw[0] = 32'h2801000a; pw[1] = 32'h28020014;
      pw[2] = 32'h28030019; pw[3] = 32'h0ce77800;
      pw[4] = 32'h0ce77800; pw[5] = 32'h00222000;
      pw[6] = 32'h0ce77800; pw[7] = 32'h00832800;
      pw[8] = 32'hfc000000;
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
   endtask

   initial begin
      load_nominal();

      // Reset state
      #3;
      chk_reset_outs("rst");
      step();
      rst_n = 1'b1;
      chk("rel_rdy_before", in_ready, 0);
      step();
      chk("rel_rdy_after", in_ready, 1);

      // Nominal load, CSUM = 0xe9
      clear_log();
      send_frame(16'd9, 9, 8'he9, 0);
      chk("nom_done_early", boot_done, 0);
      chk("nom_rdy_hold", in_ready, 1);
      step();
      chk("nom_done", boot_done, 1);
      chk("nom_crst", core_rst_n, 1);
      chk("nom_err", boot_err, 0);
      chk("nom_rdy_drop", in_ready, 0);
      chk_writes("nom", 9);
      chk("nom_addr_hold", 32'(mem_addr), 8);
      chk("nom_wdata_hold", mem_wdata, 32'hfc000000);
      chk("nom_we_idle", mem_we, 0);

      // Bytes offered in DONE are not consumed
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (3) step();
      in_valid = 1'b0;
      chk("done_stall_rdy", in_ready, 0);
      chk("done_stall_done", boot_done, 1);

      // Bad checksum
      pulse_start();
      chk("rearm1_crst", core_rst_n, 0);
      clear_log();
      send_frame(16'd9, 9, 8'he8, 0);
      step();
      chk("bad_err", boot_err, 1);
      chk("bad_done", boot_done, 0);
      chk("bad_crst", core_rst_n, 0);
      chk("bad_rdy", in_ready, 0);
      chk_writes("bad", 9);

      // N = 0 with CSUM 00
      pulse_start();
      chk("rearm2_err", boot_err, 0);
      clear_log();
      send_frame(16'd0, 0, 8'h00, 0);
      step();
      chk("n0_done", boot_done, 1);
      chk("n0_crst", core_rst_n, 1);
      chk("n0_writes", wa_q.size(), 0);

      // N = MAX_WORDS + 1 errors right after LEN_LO
      pulse_start();
      clear_log();
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      chk("big_err", boot_err, 1);
      chk("big_rdy", in_ready, 0);
      chk("big_crst", core_rst_n, 0);
      repeat (3) step();
      chk("big_writes", wa_q.size(), 0);

      // Random stalls give identical writes
      pulse_start();
      clear_log();
      send_frame(16'd9, 9, 8'he9, 5);
      step();
      chk("stall_done", boot_done, 1);
      chk_writes("stall", 9);

      // Reset mid-word 3
      pulse_start();
      clear_log();
      send_byte(8'h00, 0);
      send_byte(8'h09, 0);
      for (int i = 0; i < 3; i++) begin
         send_byte(pw[i][31:24], 0);
         send_byte(pw[i][23:16], 0);
         send_byte(pw[i][15:8], 0);
         send_byte(pw[i][7:0], 0);
      end
      send_byte(pw[3][31:24], 0);
      send_byte(pw[3][23:16], 0);
      rst_n = 1'b0;
      #1;
      chk_reset_outs("mid");
      repeat (3) step();
      chk("mid_writes", wa_q.size(), 3);
      rst_n = 1'b1;
      clear_log();
      send_frame(16'd9, 9, 8'he9, 0);
      step();
      chk("after_rst_done", boot_done, 1);
      chk_writes("after_rst", 9);

      // Re-arm and load a single word: de^ad^be^ef = 0x22
      pulse_start();
      chk("rearm_crst_low", core_rst_n, 0);
      chk("rearm_done_low", boot_done, 0);
      clear_log();
      pw[0] = 32'hdeadbeef;
      send_frame(16'd1, 1, 8'h22, 0);
      step();
      chk("one_done", boot_done, 1);
      chk_writes("one", 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips32_prog_loader.md
# mips32_prog_loader

Boot-time program loader sitting directly upstream of the pipelined MIPS32 core. Accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, writes them sequentially into the core's instruction memory from address 0, verifies a checksum, and only then releases the core from reset.

## Interface

Parameters:
- `ADDR_W`, default 10: instruction memory word-address width.
- `MAX_WORDS`, default 1024: largest accepted program length in words; must be ≤ 2^ADDR_W.

Ports:
- `clk1` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that re-arms the loader from DONE or ERR.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader can accept a byte; a transfer occurs when `in_valid & in_ready`.
- `mem_we` output 1: instruction-memory write strobe, one cycle per word.
- `mem_addr` output ADDR_W: word address for the write.
- `mem_wdata` output 32: instruction word.
- `core_rst_n` output 1: reset to the core; low until a load completes with a good checksum.
- `boot_done` output 1: load completed with a good checksum.
- `boot_err` output 1: load aborted (bad length or bad checksum).

## Operation

- Frame: `LEN_HI`, `LEN_LO` (16-bit word count N, big-endian), then 4·N payload bytes (each word MSB first), then one `CSUM` byte equal to the XOR of all 4·N payload bytes. Length bytes are not covered by the checksum.
- States: `S_LEN_HI` → `S_LEN_LO` → `S_DATA` → `S_CSUM` → `S_DONE`, or `S_ERR`.
  - `S_LEN_HI`: on a transfer, latch the high byte.
  - `S_LEN_LO`: on a transfer, form N. N > MAX_WORDS → `S_ERR`. N = 0 → `S_CSUM`. Otherwise → `S_DATA`.
  - `S_DATA`: shift bytes into a 32-bit assembler and XOR each byte into the running checksum. On the 4th byte of a word, register the write and increment the word counter. After word N → `S_CSUM`.
  - `S_CSUM`: on a transfer, byte equal to the running XOR → `S_DONE`; otherwise → `S_ERR`.
  - `S_DONE` / `S_ERR`: `in_ready`=0; incoming bytes are not consumed. `start` → `S_LEN_HI`, clearing the checksum, counters, `boot_done`, `boot_err`, and driving `core_rst_n` low again.
- `start` in any receive state restarts the frame from `S_LEN_HI`. Memory words already written are not erased.
- Byte counter is 2 bits and wraps within each word. The word counter is 16 bits. `mem_addr` equals the low ADDR_W bits of the word index.

## Timing

- Reset values: state `S_LEN_HI`, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_rst_n`=0, `boot_done`=0, `boot_err`=0, checksum=0.
- `in_ready` is registered. It goes to 1 the first cycle after reset release, stays 1 in all receive states, and drops in the cycle that `S_DONE` or `S_ERR` is entered. It does not drop in the cycle the CSUM byte is accepted, so a back-to-back byte after CSUM is not consumed only if it arrives after that edge; senders must not send past CSUM.
- Throughput: one byte per cycle. A gap in `in_valid` stalls with no state change.
- Write latency: `mem_we`=1 for exactly one cycle, the cycle after the edge that accepts a word's 4th byte. `mem_addr` and `mem_wdata` are valid in that cycle and hold their values afterward.
- `core_rst_n` and `boot_done` rise together on the edge entering `S_DONE`, which is one edge after the CSUM byte is accepted.
- `boot_err` rises on the edge entering `S_ERR`.
- Asserting `rst_n` mid-frame aborts immediately. All outputs return to their reset values, including `mem_we`=0, and any partial word is discarded.

## Structure

- Shared package `mips32_pkg`: the state enum, `INSTR_W`=32, and the `HALT` opcode constant 6'h3f.
- One sub-module, `mips32_word_assembler`, is natural: an 8-to-32 shift assembler with a 2-bit byte counter and a `word_valid` pulse.
- The FSM, checksum, and counters live in the top module.

## Test plan

- Nominal load: N=9 with the words 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 and the correct CSUM → 9 writes to addresses 0–8 with exact data, then `boot_done`=1 and `core_rst_n`=1. The core then produces R4=30 and R5=55.
- Bad checksum: same frame with CSUM XOR 0x01 → all 9 writes occur, `boot_err`=1, `core_rst_n` stays 0, `in_ready`=0.
- Length limits: N=0 followed by CSUM=00 → no writes, `boot_done`=1. N=MAX_WORDS+1 → `S_ERR` right after `LEN_LO`, no writes.
- Stalls: random `in_valid` gaps of 0–5 cycles → the write sequence and data are identical to the nominal load.
- Reset mid-word: drop `rst_n` after 2 bytes of word 3 → all outputs at reset values and no write for word 3. A new full frame afterward succeeds.
- Re-arm: after DONE, pulse `start` → `core_rst_n` goes low the next cycle, and a second frame with N=1 writes address 0.
